bank_group_requester: RTL and testbench

Requester side of the bank-group arbitration handshake in the memory-controller back end. One instance per bank group. It buffers scheduled requests for that bank group in a FIFO and asserts req while work is pending. On grant it drains up to a programmable number of bursts, one per cycle, onto the shared data path. It then yields so the bank-group arbiter can rotate to the next group.

---
 rtl/bank_group_requester.sv | 151 +++++++++++++++
 tb/tb_bank_group_requester.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_group_requester.sv
// Bank-group requester: buffers scheduled requests in a FIFO, raises req while
// work is pending, drains up to a latched burst limit per grant period and then
// yields for one cycle so the arbiter can rotate to another bank group.
module bank_group_requester #(
  parameter int REQ_SIZE   = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BURSTS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [REQ_SIZE-1:0]           in_data,
  input  logic [$clog2(MAX_BURSTS):0]   num_of_bursts,
  output logic                          req,
  input  logic                          grant,
  output logic                          out_valid,
  output logic [REQ_SIZE-1:0]           out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          grant_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAX_BURSTS) + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQUEST = 2'd1;
  localparam logic [1:0] S_SERVE   = 2'd2;
  localparam logic [1:0] S_YIELD   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [BW-1:0]       burst_cnt_q, burst_cnt_d;
  logic [BW-1:0]       limit_q, limit_d;
  logic [BW-1:0]       lim_clamped, cnt_inc;
  logic                out_valid_q;
  logic [REQ_SIZE-1:0] out_data_q;
  logic                grant_err_q;
  logic [REQ_SIZE-1:0] mem [FIFO_DEPTH];

  logic full, empty, push, pop, last_word;

  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign in_ready   = !full;
  assign push       = in_valid && in_ready;
  // The grant edge in REQUEST already moves the first burst.
  assign pop        = grant && !empty &&
                      ((state_q == S_REQUEST) ||
                       ((state_q == S_SERVE) && (burst_cnt_q < limit_q)));
  assign last_word  = (count_q == CW'(1)) && !push;
  assign cnt_inc    = burst_cnt_q + 1'b1;

  assign req        = (state_q == S_REQUEST) || (state_q == S_SERVE);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign fifo_count = count_q;
  assign grant_err  = grant_err_q;

  // Normalise the programmed burst limit: 0 behaves as 1, large values clamp.
  always_comb begin
    lim_clamped = num_of_bursts;
    if (num_of_bursts == '0)
      lim_clamped = BW'(1);
    else if (num_of_bursts > BW'(MAX_BURSTS))
      lim_clamped = BW'(MAX_BURSTS);
  end

  // Occupancy follows push/pop; a simultaneous pair leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Handshake FSM and per-grant burst accounting.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    limit_d     = limit_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_REQUEST;
      end
      S_REQUEST: begin
        if (grant) begin
          state_d     = S_SERVE;
          limit_d     = lim_clamped;
          burst_cnt_d = pop ? BW'(1) : '0;
        end else if (empty) begin
          state_d = S_IDLE;
        end
      end
      S_SERVE: begin
        if (!grant) begin
          // Pre-empted: re-request and start a fresh grant period later.
          state_d     = S_REQUEST;
          burst_cnt_d = '0;
        end else if (pop) begin
          burst_cnt_d = cnt_inc;
          if ((cnt_inc == limit_q) || last_word) state_d = S_YIELD;
        end else begin
          // Limit already met by the REQUEST-edge pop, or nothing left.
          state_d = S_YIELD;
        end
      end
      default: begin
        state_d = empty ? S_IDLE : S_REQUEST;
      end
    endcase
  end

  // Control state, pointers and output register with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      burst_cnt_q <= '0;
      limit_q     <= BW'(1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      grant_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      burst_cnt_q <= burst_cnt_d;
      limit_q     <= limit_d;
      out_valid_q <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        out_data_q <= mem[rd_ptr_q];
      end
      // YIELD is exempt: the arbiter observes req falling one cycle late.
      if (grant && !req && (state_q != S_YIELD)) grant_err_q <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_bank_group_requester.sv
// Scoreboard bench for bank_group_requester: accepted words are queued by the
// driver, a negedge monitor pops and compares every out_valid word and checks
// occupancy, in_ready and the per-grant burst limit.
module tb_bank_group_requester;

  logic        clk, rst, in_valid, in_ready, req, grant, out_valid, grant_err;
  logic [31:0] in_data, out_data;
  logic [2:0]  num_of_bursts;
  logic [3:0]  fifo_count;

  bank_group_requester #(.REQ_SIZE(32), .FIFO_DEPTH(8), .MAX_BURSTS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .num_of_bursts(num_of_bursts), .req(req),
    .grant(grant), .out_valid(out_valid), .out_data(out_data),
    .fifo_count(fifo_count), .grant_err(grant_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [31:0] sb[$];
  int          run = 0, max_run = 0;
  bit          mon_en = 0;
  int          gmode = 0;    // 0 manual, 1 grant follows req, 2 random grant while req
  bit          last_acc;
  int          last_tries;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int lim_of(input logic [2:0] n);
    if (n == 3'd0) return 1;
    if (n > 3'd4) return 4;
    return int'(n);
  endfunction

  // Monitor: runs after each rising edge's outputs have settled.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_no_expected got %0h expected none", out_data);
        end else begin
          chk("out_data", out_data, sb.pop_front());
        end
        run++;
        if (run > max_run) max_run = run;
        chk("burst_run_within_limit", 32'(run <= lim_of(num_of_bursts)), 1);
      end
      if (!req || !grant) run = 0;
      chk("fifo_count", 32'(fifo_count), 32'(sb.size()));
      chk("in_ready", 32'(in_ready), 32'(sb.size() < 8));
    end
  end

  // One cycle of stimulus, applied just after the monitor has sampled.
  task automatic cyc(input bit v, input logic [31:0] d);
    @(negedge clk); #1;
    in_valid = v;
    in_data  = d;
    case (gmode)
      1: grant = req;
      2: grant = req & ($urandom_range(0, 4) != 0);
      default: ;
    endcase
    last_acc = v && (sb.size() < 8);
    if (last_acc) sb.push_back(d);
  endtask

  task automatic push_word(input logic [31:0] d);
    last_tries = 0;
    do begin
      cyc(1'b1, d);
      last_tries++;
    end while (!last_acc && last_tries < 40);
    if (!last_acc) begin
      checks++; errors++;
      $display("FAIL push_timeout got tries %0d expected accept", last_tries);
    end
  endtask

  task automatic drain();
    int n = 0;
    gmode = 1;
    while ((sb.size() != 0 || req) && n < 300) begin
      cyc(1'b0, 32'h0);
      n++;
    end
    chk("drain_complete", 32'(sb.size() == 0 && !req), 1);
    cyc(1'b0, 32'h0);
    cyc(1'b0, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nout;
    bit low_between;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; grant = 1'b0; num_of_bursts = 3'd4;
    #12;
    chk("rst_req", 32'(req), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_grant_err", 32'(grant_err), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    @(negedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // 1: three words, limit 4, arbiter grants as soon as req is seen
    gmode = 1; num_of_bursts = 3'd4;
    cyc(1'b1, 32'hA1);
    chk("t1_req_before_push", 32'(req), 0);
    cyc(1'b1, 32'hA2);
    chk("t1_req_same_cycle", 32'(req), 0);
    cyc(1'b1, 32'hA3);
    chk("t1_req_rise", 32'(req), 1);
    cyc(1'b0, 32'h0);
    chk("t1_ov1", 32'(out_valid), 1);
    cyc(1'b0, 32'h0);
    chk("t1_ov2", 32'(out_valid), 1);
    cyc(1'b0, 32'h0);
    chk("t1_ov3", 32'(out_valid), 1);
    chk("t1_yield_req", 32'(req), 0);
    cyc(1'b0, 32'h0);
    chk("t1_ov_done", 32'(out_valid), 0);
    chk("t1_idle_req", 32'(req), 0);

    // 2: six words, limit 2
    num_of_bursts = 3'd2; max_run = 0;
    for (int i = 0; i < 6; i++) push_word(32'hB0 + 32'(i));
    drain();
    chk("t2_max_run", 32'(max_run), 2);
    chk("t2_count_zero", 32'(fifo_count), 0);

    // 3: fill, overflow attempt, 9th word accepted the cycle after a pop
    gmode = 0; grant = 1'b0; num_of_bursts = 3'd4;
    for (int i = 0; i < 8; i++) push_word(32'hC0 + 32'(i));
    cyc(1'b1, 32'hC8);
    chk("t3_full_in_ready", 32'(in_ready), 0);
    chk("t3_full_count", 32'(fifo_count), 8);
    cyc(1'b1, 32'hC8);
    chk("t3_still_full", 32'(in_ready), 0);
    gmode = 1;
    push_word(32'hC8);
    chk("t3_ninth_latency", 32'(last_tries), 2);
    drain();

    // 4: pre-emption after one burst, then re-grant drains the rest
    gmode = 0; grant = 1'b0; num_of_bursts = 3'd4;
    for (int i = 0; i < 5; i++) push_word(32'hD0 + 32'(i));
    cyc(1'b0, 32'h0);
    cyc(1'b0, 32'h0);
    chk("t4_req_pending", 32'(req), 1);
    grant = 1'b1;
    cyc(1'b0, 32'h0);
    chk("t4_first_burst", 32'(out_valid), 1);
    grant = 1'b0;
    cyc(1'b0, 32'h0);
    chk("t4_preempt_no_pop", 32'(out_valid), 0);
    chk("t4_preempt_req", 32'(req), 1);
    max_run = 0; nout = 0; gmode = 1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 32'h0);
      if (out_valid) nout++;
    end
    chk("t4_regrant_bursts", 32'(nout), 4);
    chk("t4_regrant_run", 32'(max_run), 4);

    // 5: num_of_bursts=0 acts as one burst per grant period
    gmode = 0; grant = 1'b0; num_of_bursts = 3'd0; max_run = 0;
    push_word(32'hE0);
    push_word(32'hE1);
    cyc(1'b0, 32'h0);
    gmode = 1; nout = 0; low_between = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 32'h0);
      if (out_valid) nout++;
      if (nout == 1 && !req) low_between = 1;
    end
    chk("t5_bursts", 32'(nout), 2);
    chk("t5_req_low_between", 32'(low_between), 1);
    chk("t5_max_run", 32'(max_run), 1);

    // 6: grant while idle is a sticky error; reset mid-SERVE clears all
    gmode = 0; grant = 1'b0; num_of_bursts = 3'd4;
    cyc(1'b0, 32'h0);
    chk("t6_err_clear", 32'(grant_err), 0);
    grant = 1'b1;
    cyc(1'b0, 32'h0);
    grant = 1'b0;
    cyc(1'b0, 32'h0);
    chk("t6_err_set", 32'(grant_err), 1);
    cyc(1'b0, 32'h0);
    cyc(1'b0, 32'h0);
    chk("t6_err_sticky", 32'(grant_err), 1);
    gmode = 1;
    for (int i = 0; i < 3; i++) push_word(32'hF0 + 32'(i));
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(1'b0, 32'h0);
      seen = out_valid;
    end
    chk("t6_reached_serve", 32'(seen), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", 32'(out_valid), 0);
    chk("t6_rst_req", 32'(req), 0);
    chk("t6_rst_count", 32'(fifo_count), 0);
    chk("t6_rst_err", 32'(grant_err), 0);
    sb.delete(); run = 0;
    gmode = 0; grant = 1'b0; in_valid = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    cyc(1'b0, 32'h0);
    cyc(1'b0, 32'h0);
    chk("t6_post_rst_req", 32'(req), 0);

    // Random traffic, random pre-emption, per-segment burst limit
    for (int s = 0; s < 3; s++) begin
      num_of_bursts = 3'($urandom_range(0, 7));
      gmode = 2;
      for (int i = 0; i < 150; i++) cyc($urandom_range(0, 9) < 6, $urandom);
      drain();
    end
    chk("rand_no_grant_err", 32'(grant_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
